// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV32 funct3 codes,
// and the store byte-enable / misalignment decode used by the controller.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Size comes from funct3[1:0]; anything that is neither byte nor half acts as a word.
  function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b00:   byte_en = 4'b0001 << addr_lo;
      2'b01:   byte_en = 4'b0011 << {addr_lo[1], 1'b0};
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr_lo[0];
      default: misaligned = |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: picks the byte/half lane out of a DRAM word and
// sign- or zero-extends it; undefined funct3 values return the whole word.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = 8'h00;
    case (addr_lo)
      2'd0: lane_b = word[7:0];
      2'd1: lane_b = word[15:8];
      2'd2: lane_b = word[23:16];
      2'd3: lane_b = word[31:24];
      default: lane_b = 8'h00;
    endcase
    lane_h = addr_lo[1] ? word[31:16] : word[15:0];

    result = word;
    case (funct3)
      F3_B:    result = {{(XLEN-8){lane_b[7]}}, lane_b};
      F3_BU:   result = {{(XLEN-8){1'b0}}, lane_b};
      F3_H:    result = {{(XLEN-16){lane_h[15]}}, lane_h};
      F3_HU:   result = {{(XLEN-16){1'b0}}, lane_h};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the MEM stage and a synchronous-read, byte-write DRAM.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses via rsp_err.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// valid, once raised, holds with its payload stable until that edge.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [2:0]         req_funct3,
  input  logic [XLEN-1:0]    req_addr,
  input  logic [XLEN-1:0]    req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [XLEN-1:0]    rsp_rdata,
  output logic               rsp_err,
  output logic [DADDR_W-1:0] dram_a,
  output logic [3:0]         dram_we,
  output logic [XLEN-1:0]    dram_din,
  input  logic [XLEN-1:0]    dram_spo
);

  lsu_state_e      state, state_nxt;
  logic [2:0]      funct3_q;
  logic [1:0]      addr_lo_q;
  logic            is_load_q;
  logic            err_q;
  logic            accept;
  logic            trap;
  logic [XLEN-1:0] store_data;
  logic [XLEN-1:0] load_val;
  logic            unused_addr_hi;

  // Upper address bits wrap: only the DRAM word index is used.
  assign unused_addr_hi = ^req_addr[XLEN-1:DADDR_W+2];

  assign accept    = (state == IDLE) && req_valid;
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = misaligned(req_funct3, req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    store_data = req_wdata;
    case (req_funct3[1:0])
      2'b00:   store_data = {(XLEN/8){req_wdata[7:0]}};
      2'b01:   store_data = {(XLEN/16){req_wdata[15:0]}};
      default: store_data = req_wdata;
    endcase
  end

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .word    (dram_spo),
    .funct3  (funct3_q),
    .addr_lo (addr_lo_q),
    .result  (load_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = (is_load_q && !err_q) ? CAPTURE : RESP;
      CAPTURE: state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // dram_we is a one-cycle pulse: set on accept, cleared on every other edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dram_a    <= '0;
      dram_we   <= '0;
      dram_din  <= '0;
      funct3_q  <= '0;
      addr_lo_q <= '0;
      is_load_q <= 1'b0;
      err_q     <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      dram_we <= '0;
      if (accept) begin
        dram_a    <= req_addr[DADDR_W+1:2];
        dram_we   <= (req_we && !trap) ? byte_en(req_funct3, req_addr[1:0]) : 4'b0000;
        dram_din  <= store_data;
        funct3_q  <= req_funct3;
        addr_lo_q <= req_addr[1:0];
        is_load_q <= !req_we;
        err_q     <= trap;
      end
      if (state == ACCESS && (!is_load_q || err_q)) begin
        rsp_rdata <= '0;
        rsp_err   <= err_q;
      end
      if (state == CAPTURE) begin
        rsp_rdata <= load_val;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule
